aclk_time_entry: RTL and testbench

- Keypad time-entry register. It collects up to four BCD digits from the keypad decoder, range-checks them as a 24-hour HH:MM value, and produces the new-time digits plus a one-cycle load strobe.
- It is the writer side of the new-time load interface: it drives new_current_time_*/load_new_c into aclk_counter and the alarm-load equivalent (load_new_a) into the alarm register.

---
 rtl/aclk_pkg.sv | 28 ++
 rtl/aclk_time_valid.sv | 26 ++
 rtl/aclk_time_entry.sv | 141 ++++++++++++++
 tb/tb_aclk_time_entry.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock time-entry path: state encoding,
// BCD range limits and the digit-buffer layout.
package aclk_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ENTRY    = 3'd1;
  localparam logic [2:0] ST_COMMIT_C = 3'd2;
  localparam logic [2:0] ST_COMMIT_A = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  localparam logic [3:0] MAX_MS_HR      = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;
  localparam logic [3:0] MAX_BCD        = 4'd9;
  localparam logic [2:0] ENTRY_DIGITS   = 3'd4;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } time_digits_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= MAX_BCD;
  endfunction

endpackage

// File: rtl/aclk_time_valid.sv
// Combinational 24-hour HH:MM range check on four BCD digits. Shared by the
// time and alarm commit paths.
module aclk_time_valid
  import aclk_pkg::*;
(
  input  time_digits_t digits,
  input  logic         count_full,
  output logic         valid
);

  logic hr_ok;
  logic min_ok;

  // Hours 00-23 and minutes 00-59; an incomplete buffer is never valid.
  always_comb begin
    hr_ok  = 1'b0;
    min_ok = 1'b0;
    if (digits.ms_hr < MAX_MS_HR)
      hr_ok = (digits.ls_hr <= MAX_BCD);
    else if (digits.ms_hr == MAX_MS_HR)
      hr_ok = (digits.ls_hr <= MAX_LS_HR_AT_2);
    min_ok = (digits.ms_min <= MAX_MS_MIN) && (digits.ls_min <= MAX_BCD);
    valid  = count_full && hr_ok && min_ok;
  end

endmodule

// File: rtl/aclk_time_entry.sv
// Keypad time-entry register: shifts in BCD digits, range-checks them as HH:MM
// and issues a one-cycle load strobe to the time counter or alarm register.
// Optional entry timeout enabled by defining ACLK_ENTRY_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | buffer empty, waiting for first digit
// ENTRY     | collecting digits
// COMMIT_C  | load_new_c high, digits held
// COMMIT_A  | load_new_a high, digits held
// ERROR     | entry_error high, digits held
module aclk_time_entry
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       cancel,
  output logic [3:0] new_current_time_ms_hr,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       entry_error,
  output logic       entry_active,
  output logic [2:0] digit_count
);

  logic [2:0]   state_q, state_d;
  time_digits_t digits_q, digits_d;
  logic [2:0]   count_q, count_d;
  logic         any_cmd;
  logic         key_acc;
  logic         entry_valid;
  logic         tmo_expired;

  assign any_cmd = set_time | set_alarm | cancel;
  assign key_acc = key_valid && is_digit(key) && !any_cmd &&
                   ((state_q == ST_IDLE) || (state_q == ST_ENTRY));

  aclk_time_valid u_valid (
    .digits     (digits_q),
    .count_full (count_q == ENTRY_DIGITS),
    .valid      (entry_valid)
  );

`ifdef ACLK_ENTRY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_SEC);

  logic [CW-1:0] tmo_q, tmo_d;

  assign tmo_expired = (tmo_q == TMO_LIMIT);

  // Count seconds of inactivity while in ENTRY; any key or exit restarts it.
  always_comb begin
    tmo_d = tmo_q;
    if ((state_d != ST_ENTRY) || key_acc)
      tmo_d = '0;
    else if (one_second && !tmo_expired)
      tmo_d = tmo_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = one_second ^ (TIMEOUT_SEC == 0);
  assign tmo_expired    = 1'b0;
`endif

  // Next-state and buffer update; cancel beats commit beats key beats timeout.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (cancel) begin
          state_d  = ST_IDLE;
          digits_d = '0;
          count_d  = '0;
        end else if ((state_q == ST_ENTRY) && (set_time || set_alarm)) begin
          if (set_time && set_alarm) state_d = ST_ERROR;
          else if (!entry_valid)     state_d = ST_ERROR;
          else if (set_time)         state_d = ST_COMMIT_C;
          else                       state_d = ST_COMMIT_A;
        end else if (key_acc) begin
          digits_d.ms_hr  = digits_q.ls_hr;
          digits_d.ls_hr  = digits_q.ms_min;
          digits_d.ms_min = digits_q.ls_min;
          digits_d.ls_min = key;
          if (count_q != ENTRY_DIGITS) count_d = count_q + 3'd1;
          state_d = ST_ENTRY;
        end else if ((state_q == ST_ENTRY) && tmo_expired) begin
          state_d  = ST_IDLE;
          digits_d = '0;
          count_d  = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        digits_d = '0;
        count_d  = '0;
      end
    endcase
  end

  // State, digit buffer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

  assign new_current_time_ms_hr  = digits_q.ms_hr;
  assign new_current_time_ls_hr  = digits_q.ls_hr;
  assign new_current_time_ms_min = digits_q.ms_min;
  assign new_current_time_ls_min = digits_q.ls_min;
  assign load_new_c   = (state_q == ST_COMMIT_C);
  assign load_new_a   = (state_q == ST_COMMIT_A);
  assign entry_error  = (state_q == ST_ERROR);
  assign entry_active = (state_q == ST_ENTRY);
  assign digit_count  = count_q;

endmodule

// File: tb/tb_aclk_time_entry.sv
// Self-checking bench for aclk_time_entry. Expected strobe events are queued
// when a command is driven and matched against strobes seen on the outputs.
module tb_aclk_time_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       set_time = 1'b0;
  logic       set_alarm = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, entry_error, entry_active;
  logic [2:0] digit_count;
  logic [15:0] dig;

  int vectors = 0;
  int miscompares = 0;

  // strobes = {load_new_c, load_new_a, entry_error}
  typedef struct packed {
    logic [2:0]  strobes;
    logic [15:0] digits;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  always #5 clk = ~clk;

  assign dig = {ms_hr, ls_hr, ms_min, ls_min};

  aclk_time_entry #(.TIMEOUT_SEC(3)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .one_second              (one_second),
    .key_valid               (key_valid),
    .key                     (key),
    .set_time                (set_time),
    .set_alarm               (set_alarm),
    .cancel                  (cancel),
    .new_current_time_ms_hr  (ms_hr),
    .new_current_time_ls_hr  (ls_hr),
    .new_current_time_ms_min (ms_min),
    .new_current_time_ls_min (ls_min),
    .load_new_c              (load_new_c),
    .load_new_a              (load_new_a),
    .entry_error             (entry_error),
    .entry_active            (entry_active),
    .digit_count             (digit_count)
  );

  // One clock; sample 1 ns after the edge and log any strobe seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if ({load_new_c, load_new_a, entry_error} != 3'b000)
      obs_q.push_back({load_new_c, load_new_a, entry_error, dig});
  endtask

  task automatic press(input logic [3:0] k);
    key = k; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic command(input logic st, input logic sa, input logic cn);
    set_time = st; set_alarm = sa; cancel = cn;
    tick();
    set_time = 1'b0; set_alarm = 1'b0; cancel = 1'b0;
  endtask

  task automatic pulse();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    tick();
  endtask

  task automatic press4(input logic [15:0] d);
    press(d[15:12]); press(d[11:8]); press(d[7:4]); press(d[3:0]);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({dig, digit_count, load_new_c, load_new_a, entry_error, entry_active} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got dig=%h cnt=%0d c=%b a=%b e=%b act=%b, want all 0",
               dig, digit_count, load_new_c, load_new_a, entry_error, entry_active);
    end
    #2 reset = 1'b1;
    tick();
    press(4'd1); press(4'd2);
    vectors++;
    if (digit_count !== 3'd2 || dig !== 16'h0012 || entry_active !== 1'b1) begin
      miscompares++;
      $display("FAIL two_keys: got cnt=%0d dig=%h act=%b, want 2 0012 1", digit_count, dig, entry_active);
    end
    reset = 1'b0; #2;
    vectors++;
    if (digit_count !== 3'd0 || dig !== 16'h0 || entry_active !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_entry: got cnt=%0d dig=%h act=%b, want 0 0000 0", digit_count, dig, entry_active);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_no_strobe: got %0d strobes, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_set_time();
    press4(16'h1234);
    vectors++;
    if (digit_count !== 3'd4 || dig !== 16'h1234) begin
      miscompares++;
      $display("FAIL set_time_buffer: got cnt=%0d dig=%h, want 4 1234", digit_count, dig);
    end
    exp_q.push_back({3'b100, 16'h1234});
    command(1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (dig !== 16'h0 || digit_count !== 3'd0 || {load_new_c, load_new_a, entry_error} !== 3'b000) begin
      miscompares++;
      $display("FAIL set_time_clear: got dig=%h cnt=%0d strobes=%b, want 0000 0 000",
               dig, digit_count, {load_new_c, load_new_a, entry_error});
    end
    press4(16'h1959); exp_q.push_back({3'b100, 16'h1959}); command(1'b1, 1'b0, 1'b0); tick();
    press4(16'h2360); exp_q.push_back({3'b001, 16'h2360}); command(1'b1, 1'b0, 1'b0); tick();
    press4(16'h1234); exp_q.push_back({3'b001, 16'h1234}); command(1'b1, 1'b1, 1'b0); tick();
    while (exp_q.size() != 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL set_time_event: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL set_time_event: got %h, want %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL set_time_extra: got %0d extra strobes, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_set_alarm();
    press4(16'h2400); exp_q.push_back({3'b001, 16'h2400}); command(1'b0, 1'b1, 1'b0); tick();
    press4(16'h2359); exp_q.push_back({3'b010, 16'h2359}); command(1'b0, 1'b1, 1'b0);
    vectors++;
    if (load_new_a !== 1'b1 || dig !== 16'h2359) begin
      miscompares++;
      $display("FAIL alarm_strobe: got a=%b dig=%h, want 1 2359", load_new_a, dig);
    end
    tick();
    while (exp_q.size() != 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL alarm_event: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL alarm_event: got %h, want %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL alarm_extra: got %0d extra strobes, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_digit_count();
    press(4'd1); press(4'd2); press(4'd3);
    exp_q.push_back({3'b001, 16'h0123}); command(1'b1, 1'b0, 1'b0); tick();
    press(4'd0); press(4'd9); press(4'd7); press(4'd5); press(4'd8);
    vectors++;
    if (digit_count !== 3'd4 || dig !== 16'h9758) begin
      miscompares++;
      $display("FAIL overflow_keep_last: got cnt=%0d dig=%h, want 4 9758", digit_count, dig);
    end
    exp_q.push_back({3'b001, 16'h9758}); command(1'b1, 1'b0, 1'b0); tick();
    press(4'd9); press4(16'h1234);
    exp_q.push_back({3'b100, 16'h1234}); command(1'b1, 1'b0, 1'b0); tick();
    while (exp_q.size() != 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL count_event: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL count_event: got %h, want %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL count_extra: got %0d extra strobes, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_cancel_ignore();
    key = 4'd5; key_valid = 1'b1; cancel = 1'b1;
    tick();
    key_valid = 1'b0; cancel = 1'b0;
    vectors++;
    if (digit_count !== 3'd0 || dig !== 16'h0 || entry_active !== 1'b0) begin
      miscompares++;
      $display("FAIL key_with_cancel: got cnt=%0d dig=%h act=%b, want 0 0000 0", digit_count, dig, entry_active);
    end
    command(1'b1, 1'b0, 1'b0); tick();
    press(4'hB);
    vectors++;
    if (digit_count !== 3'd0 || entry_active !== 1'b0) begin
      miscompares++;
      $display("FAIL non_digit_key: got cnt=%0d act=%b, want 0 0", digit_count, entry_active);
    end
    press(4'd7); press(4'd8); command(1'b0, 1'b0, 1'b1);
    vectors++;
    if (digit_count !== 3'd0 || dig !== 16'h0 || entry_active !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_entry: got cnt=%0d dig=%h act=%b, want 0 0000 0", digit_count, dig, entry_active);
    end
    press4(16'h0815); exp_q.push_back({3'b100, 16'h0815}); command(1'b1, 1'b0, 1'b0);
    press(4'd9);
    vectors++;
    if (digit_count !== 3'd0 || entry_active !== 1'b0) begin
      miscompares++;
      $display("FAIL key_during_commit: got cnt=%0d act=%b, want 0 0", digit_count, entry_active);
    end
    vectors++;
    if (exp_q.size() != obs_q.size()) begin
      miscompares++;
      $display("FAIL cancel_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end else if (obs_q.size() != 0 && obs_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL cancel_events: got %h, want %h", obs_q[0], exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
`ifdef ACLK_ENTRY_TIMEOUT_EN
    press(4'd1); pulse(); pulse();
    one_second = 1'b1; tick(); one_second = 1'b0;
    vectors++;
    if (entry_active !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_at_limit: got act=%b, want 1", entry_active);
    end
    tick();
    vectors++;
    if (entry_active !== 1'b0 || digit_count !== 3'd0 || dig !== 16'h0) begin
      miscompares++;
      $display("FAIL timeout_expire: got act=%b cnt=%0d dig=%h, want 0 0 0000", entry_active, digit_count, dig);
    end
    press(4'd1); pulse(); pulse(); press(4'd2); pulse(); pulse();
    vectors++;
    if (entry_active !== 1'b1 || digit_count !== 3'd2) begin
      miscompares++;
      $display("FAIL timeout_key_restart: got act=%b cnt=%0d, want 1 2", entry_active, digit_count);
    end
    command(1'b0, 1'b0, 1'b1);
    press4(16'h1234); pulse(); pulse();
    one_second = 1'b1; tick(); one_second = 1'b0;
    exp_q.push_back({3'b100, 16'h1234}); command(1'b1, 1'b0, 1'b0); tick();
`else
    press(4'd1); pulse(); pulse(); pulse(); pulse(); pulse();
    vectors++;
    if (entry_active !== 1'b1 || digit_count !== 3'd1) begin
      miscompares++;
      $display("FAIL no_timeout_persist: got act=%b cnt=%0d, want 1 1", entry_active, digit_count);
    end
    command(1'b0, 1'b0, 1'b1);
`endif
    vectors++;
    if (exp_q.size() != obs_q.size()) begin
      miscompares++;
      $display("FAIL timeout_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end else if (obs_q.size() != 0 && obs_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL timeout_events: got %h, want %h", obs_q[0], exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_commit();
    press4(16'h1234);
    exp_q.push_back({3'b100, 16'h1234});
    command(1'b1, 1'b0, 1'b0);
    reset = 1'b0; #1;
    vectors++;
    if ({dig, digit_count, load_new_c, load_new_a, entry_error, entry_active} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_mid_commit: got dig=%h cnt=%0d c=%b a=%b e=%b act=%b, want all 0",
               dig, digit_count, load_new_c, load_new_a, entry_error, entry_active);
    end
    #2 reset = 1'b1;
    tick();
    vectors++;
    if (exp_q.size() != obs_q.size()) begin
      miscompares++;
      $display("FAIL reset_commit_events: got %0d strobes, want %0d", obs_q.size(), exp_q.size());
    end else if (obs_q.size() != 0 && obs_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL reset_commit_events: got %h, want %h", obs_q[0], exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_set_alarm();
    test_digit_count();
    test_cancel_ignore();
    test_timeout();
    test_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
